uart_tx_feeder: RTL and testbench

Byte-buffering front end for the `uart` transmitter. It accepts bytes from the debug/trace logic of the virtual DS2431 on a simple write strobe, stores them in a small FIFO, and presents them one at a time to `uart` over its `txByte`/`txTrig`/`txDone` handshake. Producers are decoupled from the serial bit rate. Overflow and a stalled-transmitter timeout are reported as sticky flags.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_feeder.sv | 89 ++++++++
 tb/tb_uart_tx_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the uart transmit path.
package uart_pkg;

   localparam int BYTE_W = 8;

   // Feeder handshake states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRIG      = 2'd1,
      WAIT_DONE = 2'd2
   } feedState_t;

   // Baud-select codes understood by uart.
   typedef enum logic [2:0] {
      BAUD_9600   = 3'd0,
      BAUD_19200  = 3'd1,
      BAUD_38400  = 3'd2,
      BAUD_57600  = 3'd3,
      BAUD_115200 = 3'd4
   } baudSel_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with count register; push ignored when full, pop ignored when empty.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH      = BYTE_W,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wrData,
   output logic [WIDTH-1:0]      rdData,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] rdPtr;
   logic                  doPush;
   logic                  doPop;

   assign full   = level == (DEPTH_LOG2 + 1)'(DEPTH);
   assign empty  = level == '0;
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign rdData = mem[rdPtr];

   // Storage array; contents need no reset since the count guards every read.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wrData;
   end

   // Pointers wrap naturally; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
      end else begin
         wrPtr <= wrPtr + DEPTH_LOG2'(doPush);
         rdPtr <= rdPtr + DEPTH_LOG2'(doPop);
         level <= level + (DEPTH_LOG2 + 1)'(doPush) - (DEPTH_LOG2 + 1)'(doPop);
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and hands them to uart one at a time over txTrig/txDone.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2  = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  wrEn,
   input  logic [BYTE_W-1:0]     wrData,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ovf,
   output logic                  tmo,
   input  logic                  clrErr,
   output logic                  busy,
   output logic [BYTE_W-1:0]     txByte,
   output logic                  txTrig,
   input  logic                  txDone
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   feedState_t         state;
   feedState_t         nextState;
   logic               empty;
   logic               popHead;
   logic               tmoHit;
   logic [CW-1:0]      tmoCnt;
   logic [BYTE_W-1:0]  head;

   sync_fifo #(
      .WIDTH      (BYTE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) fifo (
      .clk    (clk),
      .nRst   (nRst),
      .push   (wrEn),
      .pop    (popHead),
      .wrData (wrData),
      .rdData (head),
      .full   (full),
      .empty  (empty),
      .level  (level)
   );

   assign busy = state != IDLE;

   // Next state: pop when the transmitter is idle, hold trigger until it acknowledges or times out.
   always_comb begin
      nextState = state;
      popHead   = 1'b0;
      tmoHit    = 1'b0;
      case (state)
         IDLE: if (!empty && txDone) begin
            popHead   = 1'b1;
            nextState = TRIG;
         end
         TRIG: if (!txDone) nextState = WAIT_DONE;
            else if (tmoCnt == CW'(ACK_TIMEOUT - 1)) begin
               tmoHit    = 1'b1;
               nextState = IDLE;
            end
         WAIT_DONE: if (txDone) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State, output byte, registered trigger (one cycle behind TRIG), timeout counter and sticky flags.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state  <= IDLE;
         txByte <= '0;
         txTrig <= 1'b0;
         tmoCnt <= '0;
         ovf    <= 1'b0;
         tmo    <= 1'b0;
      end else begin
         state  <= nextState;
         txByte <= popHead ? head : txByte;
         txTrig <= state == TRIG;
         tmoCnt <= state == TRIG ? tmoCnt + CW'(1) : '0;
         ovf    <= (wrEn && full) || (ovf && !clrErr);
         tmo    <= tmoHit || (tmo && !clrErr);
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scoreboard bench with a behavioural uart stub on txTrig/txDone.
module tb_uart_tx_feeder;

   localparam int DL    = 4;
   localparam int TMO   = 15;
   localparam int M_NORM = 0;
   localparam int M_LOW  = 1;
   localparam int M_IGN  = 2;

   logic          clk    = 1'b0;
   logic          nRst   = 1'b0;
   logic          wrEn   = 1'b0;
   logic [7:0]    wrData = 8'h00;
   logic          clrErr = 1'b0;
   logic          txDone = 1'b1;
   logic          full;
   logic [DL:0]   level;
   logic          ovf;
   logic          tmo;
   logic          busy;
   logic [7:0]    txByte;
   logic          txTrig;

   int            checks   = 0;
   int            failures = 0;
   int            stubMode = M_NORM;
   logic [7:0]    expQ[$];

   int            ackDly  = 0;
   int            lowCnt  = 0;
   logic          stubPrev = 1'b0;
   logic          rise;
   logic [7:0]    held    = 8'h00;
   logic          monPrev = 1'b0;
   logic [7:0]    expByte;

   uart_tx_feeder #(.DEPTH_LOG2(DL), .ACK_TIMEOUT(TMO)) dut (
      .clk    (clk),
      .nRst   (nRst),
      .wrEn   (wrEn),
      .wrData (wrData),
      .full   (full),
      .level  (level),
      .ovf    (ovf),
      .tmo    (tmo),
      .clrErr (clrErr),
      .busy   (busy),
      .txByte (txByte),
      .txTrig (txTrig),
      .txDone (txDone)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] b, input bit acc);
      @(negedge clk);
      wrEn   = 1'b1;
      wrData = b;
      if (acc) expQ.push_back(b);
      @(posedge clk);
      #1;
      wrEn = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (!(!busy && level == 0 && txDone && !txTrig) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_reached", 32'(n < 3000), 1);
   endtask

   // uart stub: acknowledges a trigger rise within 1-2 cycles, stays busy 20-40 cycles.
   initial forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) begin
         txDone   = 1'b1;
         ackDly   = 0;
         lowCnt   = 0;
         stubPrev = 1'b0;
      end else begin
         #1;
         rise     = txTrig && !stubPrev;
         stubPrev = txTrig;
         if (stubMode == M_NORM && rise) ackDly = int'($urandom_range(2, 1));
         if (stubMode == M_LOW) txDone = 1'b0;
         else if (stubMode == M_IGN) txDone = 1'b1;
         else if (ackDly > 0) begin
            ackDly--;
            if (ackDly == 0) begin
               txDone = 1'b0;
               lowCnt = int'($urandom_range(40, 20));
               held   = txByte;
            end
         end else if (lowCnt > 0) begin
            lowCnt--;
            if (lowCnt == 0) begin
               check("txbyte_stable", 32'(txByte), 32'(held));
               txDone = 1'b1;
            end
         end else txDone = 1'b1;
      end
   end

   // Monitor: every trigger rise must present the oldest accepted, not yet sent byte.
   initial forever begin
      @(negedge clk);
      if (!nRst) monPrev = 1'b0;
      else begin
         if (txTrig && !monPrev) begin
            check("trig_has_expected", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
               expByte = expQ.pop_front();
               check("trig_byte", 32'(txByte), 32'(expByte));
            end
         end
         monPrev = txTrig;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      int hi;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({txByte, txTrig, full, level, ovf, tmo, busy}), 0);
      @(negedge clk);
      nRst = 1'b1;
      cyc(2);

      wr(8'hA5, 1);
      check("lat_level_n", 32'(level), 1);
      check("lat_trig_n", 32'(txTrig), 0);
      cyc(1);
      check("lat_level_n1", 32'(level), 0);
      check("lat_busy_n1", 32'(busy), 1);
      check("lat_trig_n1", 32'(txTrig), 0);
      cyc(1);
      check("lat_trig_n2", 32'(txTrig), 1);
      check("lat_txbyte", 32'(txByte), 32'h A5);
      waitIdle();
      check("single_busy_clear", 32'(busy), 0);

      for (int r = 0; r < 20; r++) begin
         k = int'($urandom_range(15, 1));
         for (int i = 0; i < k; i++) wr(8'($urandom), 1);
         check("burst_level", 32'(level), k == 1 ? 1 : k - 1);
         check("burst_full", 32'(full), 0);
         waitIdle();
      end
      check("burst_drain", 32'(expQ.size()), 0);

      stubMode = M_IGN;
      wr(8'h3C, 1);
      hi = 0;
      n  = 0;
      while (n < 100 && !(hi > 0 && !txTrig)) begin
         @(negedge clk);
         if (txTrig) hi++;
         n++;
      end
      check("tmo_trig_cycles", 32'(hi), TMO);
      check("tmo_flag", 32'(tmo), 1);
      check("tmo_level", 32'(level), 0);
      check("tmo_busy", 32'(busy), 0);
      @(negedge clk);
      clrErr = 1'b1;
      @(posedge clk);
      #1;
      clrErr = 1'b0;
      check("tmo_clear", 32'(tmo), 0);
      stubMode = M_NORM;

      waitIdle();
      stubMode = M_LOW;
      cyc(2);
      for (int i = 0; i < 16; i++) wr(8'($urandom_range(254, 0)), 1);
      check("fill_level", 32'(level), 16);
      check("fill_full", 32'(full), 1);
      check("fill_ovf", 32'(ovf), 0);
      wr(8'hFF, 0);
      check("ovf_set", 32'(ovf), 1);
      check("ovf_level", 32'(level), 16);
      @(negedge clk);
      wrEn   = 1'b1;
      wrData = 8'hEE;
      clrErr = 1'b1;
      @(posedge clk);
      #1;
      wrEn   = 1'b0;
      clrErr = 1'b0;
      check("ovf_set_wins", 32'(ovf), 1);
      @(negedge clk);
      clrErr = 1'b1;
      @(posedge clk);
      #1;
      clrErr = 1'b0;
      check("ovf_clear", 32'(ovf), 0);
      check("ovf_level_kept", 32'(level), 16);
      stubMode = M_NORM;
      waitIdle();
      check("ovf_drain", 32'(expQ.size()), 0);

      stubMode = M_LOW;
      cyc(2);
      wr(8'hA1, 1);
      check("same_pre_level", 32'(level), 1);
      check("same_pre_busy", 32'(busy), 0);
      @(negedge clk);
      stubMode = M_NORM;
      @(posedge clk);
      #2;
      wr(8'h77, 1);
      check("same_level", 32'(level), 1);
      check("same_busy", 32'(busy), 1);
      waitIdle();
      check("same_drain", 32'(expQ.size()), 0);

      wr(8'h55, 1);
      for (int i = 0; i < 4; i++) wr(8'($urandom), 1);
      n = 0;
      while (txDone && n < 50) begin
         cyc(1);
         n++;
      end
      check("mid_ack_seen", 32'(txDone), 0);
      cyc(8);
      @(negedge clk);
      nRst = 1'b0;
      expQ.delete();
      #1;
      check("mid_reset_outputs", 32'({txByte, txTrig, full, level, ovf, tmo, busy}), 0);
      @(negedge clk);
      nRst = 1'b1;
      cyc(40);
      check("post_reset_quiet", 32'({txTrig, busy, level}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
